// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry
//
// Scans a 4x4 active-low matrix keypad and debounces whole scan frames.
// Three accepted keys in a row become the ALU inputs: operand A, operand B,
// and then the opcode.
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active low
//   key_row      keypad rows (active low, pulled up, asynchronous to clk)
//   key_col      column drive (active-low one-hot)
//   key_code     hex value of the last accepted key
//   key_strobe   one-cycle pulse per accepted key
//   operandA     first ALU operand
//   operandB     second ALU operand
//   opcode       ALU operation select
//   entry_state  0=WAIT_A, 1=WAIT_B, 2=WAIT_OP, 3=DONE
//   valid        high while entry_state is DONE
module keypad_operand_entry #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic [3:0] operandA,
  output logic [3:0] operandB,
  output logic [2:0] opcode,
  output logic [1:0] entry_state,
  output logic       valid
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    DB_IDLE = 2'd0,
    DB_CAND = 2'd1,
    DB_HELD = 2'd2
  } db_state_t;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    DONE    = 2'd3
  } entry_state_t;

  // Synchronizer and scan state
  logic [3:0]    row_meta_q, row_sync_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;

  // Per-frame accumulation: number of lows seen so far (saturates at 2)
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_val_q, acc_val_d;

  // Debounce state
  db_state_t     db_state_q, db_state_d;
  logic [3:0]    cand_val_q, cand_val_d;
  logic [CW-1:0] match_cnt_q, match_cnt_d;
  logic [CW-1:0] release_cnt_q, release_cnt_d;

  // Entry state and outputs
  entry_state_t  entry_q, entry_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_strobe_q, key_strobe_d;
  logic [3:0]    operand_a_q, operand_a_d;
  logic [3:0]    operand_b_q, operand_b_d;
  logic [2:0]    opcode_q, opcode_d;

  // Combinational helpers
  logic          slot_end, frame_end;
  logic [2:0]    slot_cnt;
  logic [1:0]    slot_row;
  logic [3:0]    slot_val;
  logic [2:0]    frame_sum;
  logic [3:0]    frame_val;
  logic          frame_none, frame_single;
  logic          accept;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    case ({row, col})
      4'h0: v = 4'h1;  4'h1: v = 4'h2;  4'h2: v = 4'h3;  4'h3: v = 4'hA;
      4'h4: v = 4'h4;  4'h5: v = 4'h5;  4'h6: v = 4'h6;  4'h7: v = 4'hB;
      4'h8: v = 4'h7;  4'h9: v = 4'h8;  4'hA: v = 4'h9;  4'hB: v = 4'hC;
      4'hC: v = 4'hE;  4'hD: v = 4'h0;  4'hE: v = 4'hF;  default: v = 4'hD;
    endcase
    return v;
  endfunction

  // Column timing and per-slot/per-frame classification of the sampled rows.
  always_comb begin
    slot_end  = (div_cnt_q == DIV_LAST);
    frame_end = slot_end && (col_idx_q == 2'd3);
    div_cnt_d = slot_end ? '0 : div_cnt_q + DW'(1);
    col_idx_d = slot_end ? col_idx_q + 2'd1 : col_idx_q;

    slot_cnt = '0;
    slot_row = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        slot_cnt = slot_cnt + 3'd1;
        slot_row = 2'(r);
      end
    end
    slot_val = key_map(slot_row, col_idx_q);

    // frame_val is only meaningful when exactly one low has been seen
    frame_sum    = {1'b0, acc_cnt_q} + slot_cnt;
    frame_val    = (acc_cnt_q == 2'd0) ? slot_val : acc_val_q;
    frame_none   = frame_end && (frame_sum == 3'd0);
    frame_single = frame_end && (frame_sum == 3'd1);

    acc_cnt_d = acc_cnt_q;
    acc_val_d = acc_val_q;
    if (frame_end) begin
      acc_cnt_d = '0;
      acc_val_d = '0;
    end else if (slot_end) begin
      acc_cnt_d = (frame_sum >= 3'd2) ? 2'd2 : frame_sum[1:0];
      acc_val_d = frame_val;
    end
  end

  // Debounce FSM, evaluated once per frame. MULTI frames fall into the
  // "not SINGLE" and "not NONE" branches, so they neither accept nor release.
  always_comb begin
    db_state_d    = db_state_q;
    cand_val_d    = cand_val_q;
    match_cnt_d   = match_cnt_q;
    release_cnt_d = release_cnt_q;
    accept        = 1'b0;

    if (frame_end) begin
      case (db_state_q)
        DB_IDLE: begin
          if (frame_single) begin
            db_state_d  = DB_CAND;
            cand_val_d  = frame_val;
            match_cnt_d = CW'(1);
          end
        end
        DB_CAND: begin
          if (frame_single) begin
            if (frame_val == cand_val_q) begin
              match_cnt_d = match_cnt_q + CW'(1);
            end else begin
              cand_val_d  = frame_val;
              match_cnt_d = CW'(1);
            end
          end else begin
            db_state_d  = DB_IDLE;
            match_cnt_d = '0;
          end
        end
        DB_HELD: begin
          if (frame_none) begin
            if (release_cnt_q + CW'(1) == CNT_MAX) begin
              db_state_d    = DB_IDLE;
              release_cnt_d = '0;
            end else begin
              release_cnt_d = release_cnt_q + CW'(1);
            end
          end else begin
            release_cnt_d = '0;
          end
        end
        default: begin
          db_state_d = DB_IDLE;
        end
      endcase

      // Checked after the update so DEBOUNCE_FRAMES == 1 accepts straight from IDLE
      if (db_state_d == DB_CAND && match_cnt_d == CNT_MAX) begin
        accept        = 1'b1;
        db_state_d    = DB_HELD;
        match_cnt_d   = '0;
        release_cnt_d = '0;
      end
    end
  end

  // Entry FSM: only an accepted key moves it.
  always_comb begin
    entry_d      = entry_q;
    key_code_d   = key_code_q;
    key_strobe_d = 1'b0;
    operand_a_d  = operand_a_q;
    operand_b_d  = operand_b_q;
    opcode_d     = opcode_q;

    if (accept) begin
      key_code_d   = frame_val;
      key_strobe_d = 1'b1;
      case (entry_q)
        WAIT_A: begin
          operand_a_d = frame_val;
          entry_d     = WAIT_B;
        end
        WAIT_B: begin
          operand_b_d = frame_val;
          entry_d     = WAIT_OP;
        end
        WAIT_OP: begin
          // Keys 8..F are not opcodes; they are reported but otherwise ignored
          if (!frame_val[3]) begin
            opcode_d = frame_val[2:0];
            entry_d  = DONE;
          end
        end
        default: begin
          operand_a_d = frame_val;
          entry_d     = WAIT_B;
        end
      endcase
    end
  end

  // Synchronizer, scan counters and frame accumulator.
  // Synchronizer idles high, which matches the pulled-up, no-key row state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_cnt_q  <= '0;
      col_idx_q  <= '0;
      acc_cnt_q  <= '0;
      acc_val_q  <= '0;
    end else begin
      row_meta_q <= key_row;
      row_sync_q <= row_meta_q;
      div_cnt_q  <= div_cnt_d;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_val_q  <= acc_val_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_state_q    <= DB_IDLE;
      cand_val_q    <= '0;
      match_cnt_q   <= '0;
      release_cnt_q <= '0;
    end else begin
      db_state_q    <= db_state_d;
      cand_val_q    <= cand_val_d;
      match_cnt_q   <= match_cnt_d;
      release_cnt_q <= release_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q      <= WAIT_A;
      key_code_q   <= '0;
      key_strobe_q <= 1'b0;
      operand_a_q  <= '0;
      operand_b_q  <= '0;
      opcode_q     <= '0;
    end else begin
      entry_q      <= entry_d;
      key_code_q   <= key_code_d;
      key_strobe_q <= key_strobe_d;
      operand_a_q  <= operand_a_d;
      operand_b_q  <= operand_b_d;
      opcode_q     <= opcode_d;
    end
  end

  assign key_col     = ~(4'b0001 << col_idx_q);
  assign key_code    = key_code_q;
  assign key_strobe  = key_strobe_q;
  assign operandA    = operand_a_q;
  assign operandB    = operand_b_q;
  assign opcode      = opcode_q;
  assign entry_state = entry_q;
  assign valid       = (entry_q == DONE);

endmodule
